// File: rtl/popcount10_weight_enum_pkg.sv
// -----------------------------------------------------------------------------
// popcount_pkg
// Shared constants, FSM state type and helper functions for the weight-k
// vector enumerator.
//   N      vector width (number of popcount inputs)
//   W      weight field width, clog2(N+1)
//   IDX_W  run ordinal width, wide enough for C(N, N/2) - 1
// Helpers:
//   first_vec(k)  smallest N-bit vector with k ones (ones packed at the LSB end)
//   last_vec(k)   largest N-bit vector with k ones (ones packed at the MSB end)
//   binom(n, k)   binomial coefficient, used to size and check runs
// -----------------------------------------------------------------------------
package popcount_pkg;

    localparam int N     = 10;
    localparam int W     = 4;
    localparam int IDX_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // (1 << k) - 1, computed one bit wider so k == N does not overflow.
    function automatic logic [N-1:0] first_vec(input logic [W-1:0] k);
        logic [N:0] t;
        t = ({{N{1'b0}}, 1'b1} << k) - {{N{1'b0}}, 1'b1};
        return t[N-1:0];
    endfunction

    // ((1 << k) - 1) << (N - k); only meaningful for k <= N.
    function automatic logic [N-1:0] last_vec(input logic [W-1:0] k);
        logic [W-1:0] sh;
        sh = W'(N) - k;
        return first_vec(k) << sh;
    endfunction

    function automatic int binom(input int n, input int k);
        int r;
        if (k < 0 || k > n) return 0;
        r = 1;
        for (int i = 0; i < k; i++) begin
            r = (r * (n - i)) / (i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/popcount10_weight_enum_if.sv
// -----------------------------------------------------------------------------
// popcount10_weight_enum_if
// Command and output-stream handshake bundle for the weight-k enumerator.
//   cmd_valid   command valid (master -> slave)
//   cmd_ready   enumerator idle and able to take a command (slave -> master)
//   cmd_weight  target weight k (master -> slave)
//   out_valid   out_vector valid (slave -> master)
//   out_ready   consumer accepts the current vector (master -> slave)
//   out_vector  current weight-k vector
//   out_index   0-based ordinal of out_vector within the run
//   out_last    out_vector is the final vector of the run
//   err         one-cycle pulse: command rejected, k > N
// The slave modport is the enumerator's view; master is the driver/consumer.
// -----------------------------------------------------------------------------
interface popcount10_weight_enum_if;
    import popcount_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [W-1:0]     cmd_weight;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_vector;
    logic [IDX_W-1:0] out_index;
    logic             out_last;
    logic             err;

    modport master (
        output cmd_valid, cmd_weight, out_ready,
        input  cmd_ready, out_valid, out_vector, out_index, out_last, err
    );

    modport slave (
        input  cmd_valid, cmd_weight, out_ready,
        output cmd_ready, out_valid, out_vector, out_index, out_last, err
    );

endinterface

// File: rtl/popcount10_weight_enum_next_comb.sv
// -----------------------------------------------------------------------------
// popcount_next_comb
// Combinational successor: given an N-bit vector v, returns the next larger
// N-bit vector with the same number of ones (Gosper's hack).
//   v     in   N  current vector
//   next  out  N  next vector of equal popcount
// The caller never asks for the successor of the last vector of a weight
// class, so the carry out of v + c is never needed.
// -----------------------------------------------------------------------------
module popcount_next_comb
    import popcount_pkg::*;
(
    input  logic [N-1:0] v,
    output logic [N-1:0] next
);

    logic [N-1:0] low_bit;   // lowest set bit of v, isolated
    logic [N-1:0] ripple;    // v with its lowest run of ones carried upward
    logic [N-1:0] changed;   // bits flipped by the carry
    logic [W-1:0] tz;        // trailing-zero count of low_bit

    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path can leave it unassigned and
        // infer a latch.
        low_bit = v & (-v);
        ripple  = v + low_bit;
        changed = ripple ^ v;

        // low_bit is one-hot (or zero for v == 0), so scan order does not
        // matter; v == 0 only occurs for k == 0, whose successor is unused.
        tz = W'(N);
        for (int i = 0; i < N; i++) begin
            if (low_bit[i]) tz = W'(i);
        end

        // The carry flipped (run length + 1) bits starting at tz; the run's
        // remaining ones are refilled at the LSB end.
        next = ripple | (changed >> (tz + W'(2)));
    end

endmodule

// File: rtl/popcount10_weight_enum.sv
// -----------------------------------------------------------------------------
// popcount10_weight_enum
// Streams every N-bit vector with exactly k ones, one per accepted cycle, in
// ascending numeric order. A command (weight k) is taken only while idle;
// k > N is rejected with a one-cycle err pulse.
//   clk    in  1  rising-edge clock
//   rst    in  1  asynchronous reset, active-high
//   bus    slave modport of popcount10_weight_enum_if:
//          cmd_valid/cmd_ready/cmd_weight  weight command handshake
//          out_valid/out_ready             output stream handshake
//          out_vector/out_index/out_last   current vector, ordinal, end flag
//          err                             rejected-command pulse
// All outputs are registered. Command-to-first-vector latency is one cycle;
// with out_ready held high one vector is delivered per cycle.
// -----------------------------------------------------------------------------
module popcount10_weight_enum
    import popcount_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    popcount10_weight_enum_if.slave  bus
);

    state_t           state_q;
    logic [W-1:0]     weight_q;   // k latched at command accept
    logic [N-1:0]     vec_q;
    logic [IDX_W-1:0] idx_q;
    logic             last_q;
    logic             valid_q;
    logic             ready_q;
    logic             err_q;

    logic [N-1:0]     next_vec;

    popcount_next_comb u_next_comb (
        .v    (vec_q),
        .next (next_vec)
    );

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    // NOTE: every register here is small control/datapath state with a defined
    // reset value; there is no memory array, so the whole block resets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            weight_q <= '0;
            vec_q    <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            // err is a single-cycle pulse unless re-armed below.
            err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && ready_q) begin
                        if (bus.cmd_weight > W'(N)) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q  <= RUN;
                            weight_q <= bus.cmd_weight;
                            vec_q    <= first_vec(bus.cmd_weight);
                            idx_q    <= '0;
                            // Only k == 0 and k == N have first == last.
                            last_q   <= (first_vec(bus.cmd_weight) ==
                                         last_vec(bus.cmd_weight));
                            valid_q  <= 1'b1;
                            ready_q  <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    // Without an output handshake everything holds, which
                    // keeps the presented vector stable while stalled.
                    if (valid_q && bus.out_ready) begin
                        if (last_q) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            vec_q  <= next_vec;
                            idx_q  <= idx_q + IDX_W'(1);
                            last_q <= (next_vec == last_vec(weight_q));
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = ready_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_vector = vec_q;
    assign bus.out_index  = idx_q;
    assign bus.out_last   = last_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_popcount10_weight_enum.sv
// -----------------------------------------------------------------------------
// tb_popcount10_weight_enum
// Scoreboard bench: stimulus pushes the expected vector stream for each
// command into a queue; a monitor on the falling edge pops and compares on
// every output handshake, and checks that a stalled output holds still.
// -----------------------------------------------------------------------------
module tb_popcount10_weight_enum;
    import popcount_pkg::*;

    typedef struct packed {
        logic [N-1:0]     vec;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    popcount10_weight_enum_if bus ();

    popcount10_weight_enum dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   accepted = 0;

    logic rand_ready  = 1'b0;
    logic ready_level = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference stream for weight k: plain ascending scan of all N-bit values.
    task automatic push_enum(input int k);
        int total;
        int idx;
        logic [N-1:0] vv;
        total = binom(N, k);
        idx   = 0;
        for (int v = 0; v < (1 << N); v++) begin
            vv = v[N-1:0];
            if ($countones(vv) == k) begin
                q.push_back('{vec: vv, idx: IDX_W'(idx), last: (idx == total - 1)});
                idx++;
            end
        end
    endtask

    // Consumer-ready driver: fixed level or a 50% random pattern.
    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 1) == 1);
        else            bus.out_ready = ready_level;
    end

    // Monitor / scoreboard.
    logic             have_stall = 1'b0;
    logic [N-1:0]     stall_vec;
    logic [IDX_W-1:0] stall_idx;
    logic             stall_last;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            have_stall = 1'b0;
        end else begin
            if (have_stall && bus.out_valid) begin
                check("stall_vector", 32'(bus.out_vector), 32'(stall_vec));
                check("stall_index",  32'(bus.out_index),  32'(stall_idx));
                check("stall_last",   32'(bus.out_last),   32'(stall_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                accepted++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got vector 0x%0h index %0d, expected none",
                             bus.out_vector, bus.out_index);
                end else begin
                    e = q.pop_front();
                    check("out_vector", 32'(bus.out_vector), 32'(e.vec));
                    check("out_index",  32'(bus.out_index),  32'(e.idx));
                    check("out_last",   32'(bus.out_last),   32'(e.last));
                end
            end
            have_stall = bus.out_valid && !bus.out_ready;
            stall_vec  = bus.out_vector;
            stall_idx  = bus.out_index;
            stall_last = bus.out_last;
        end
    end

    // Present a command once cmd_ready is seen, holding cmd_valid for 'hold'
    // rising edges.
    task automatic send_cmd(input logic [W-1:0] k, input int hold);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!bus.cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_weight = k;
        repeat (hold) @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // Wait until the expected stream is drained and the block is idle again.
    task automatic wait_done(input string name, input int max_cycles);
        int n;
        n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < max_cycles) begin
            @(negedge clk); #1;
            n++;
        end
        check({name, "_remaining"}, 32'(q.size()), 32'd0);
        check({name, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, "_idle_ready"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_weight = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready",  32'(bus.cmd_ready),  32'd1);
        check("rst_out_valid",  32'(bus.out_valid),  32'd0);
        check("rst_out_vector", 32'(bus.out_vector), 32'd0);
        check("rst_out_index",  32'(bus.out_index),  32'd0);
        check("rst_out_last",   32'(bus.out_last),   32'd0);
        check("rst_err",        32'(bus.err),        32'd0);
        rst = 1'b0;

        // k = 0: single all-zero vector.
        q.push_back('{vec: 10'h000, idx: 8'd0, last: 1'b1});
        send_cmd(4'd0, 1);
        wait_done("k0", 20);

        // k = 1: walking one, hand-listed.
        for (int i = 0; i < N; i++) begin
            q.push_back('{vec: N'(1) << i, idx: IDX_W'(i), last: (i == N - 1)});
        end
        send_cmd(4'd1, 1);
        // First vector one cycle after accept, then one per cycle.
        n = 0;
        while (accepted == 0 && n < 5) begin @(negedge clk); n++; end
        base = accepted;
        repeat (9) @(negedge clk);
        #1 check("k1_throughput", 32'(accepted - base), 32'd9);
        wait_done("k1", 40);

        // k = 5: 252 vectors, 0x01F ... 0x3E0.
        push_enum(5);
        check("k5_first_expected", 32'(q[0].vec), 32'h01F);
        send_cmd(4'd5, 1);
        wait_done("k5", 400);

        // k = 10, with cmd_valid held through the final handshake: the
        // second presentation must not start another run.
        q.push_back('{vec: 10'h3FF, idx: 8'd0, last: 1'b1});
        send_cmd(4'd10, 2);
        wait_done("k10", 20);

        // k = 11: rejected.
        send_cmd(4'd11, 1);
        check("k11_err_pulse",  32'(bus.err),       32'd1);
        check("k11_no_valid",   32'(bus.out_valid), 32'd0);
        check("k11_cmd_ready",  32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        check("k11_err_clear",  32'(bus.err),       32'd0);
        check("k11_no_valid2",  32'(bus.out_valid), 32'd0);
        check("k11_cmd_ready2", 32'(bus.cmd_ready), 32'd1);

        // k = 3 under a random consumer.
        push_enum(3);
        rand_ready = 1'b1;
        send_cmd(4'd3, 1);
        wait_done("k3_random", 3000);
        rand_ready = 1'b0;
        @(posedge clk); #2;

        // k = 3 aborted by reset after 7 vectors, then a clean k = 2 run.
        push_enum(3);
        base = accepted;
        send_cmd(4'd3, 1);
        n = 0;
        while ((accepted - base) < 7 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("abort_accepted", 32'(accepted - base), 32'd7);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("abort_out_index", 32'(bus.out_index), 32'd0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        push_enum(2);
        check("k2_first_expected", 32'(q[0].vec), 32'h003);
        send_cmd(4'd2, 1);
        wait_done("k2", 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
